risc_register_file_responder: RTL and testbench

- Responder end of the register-read handshake that the instruction handler initiates on its A and B read ports.
- Also accepts the handler's ALU register write-back.
- Holds the 32 x 32-bit integer register file (x0 hardwired to zero).
- Each read port runs an independent four-phase valid/ack responder FSM with programmable latency. Write-back data is forwarded into reads that capture in the same cycle.

---
 rtl/risc_register_file_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_risc_register_file_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_register_file_responder.sv
// risc_register_file_responder
// Responder side of the instruction handler's register-read handshake.
// Holds the 32 x 32-bit integer register file (x0 reads as zero), serves two
// independent read ports through four-phase valid/ack FSMs with a
// programmable latency, and accepts the ALU write-back with a registered ack.
// Write-back data is forwarded into any read that captures on the same edge.
// RD_LATENCY must lie in 1..15 (the wait counter is 4 bits wide).

module risc_register_file_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] reg_rd_addr_a,
  input  logic                  reg_rd_addrs_a_valid,
  output logic [DATA_WIDTH-1:0] reg_rd_data_a,
  output logic                  reg_rd_data_a_ack,

  input  logic [ADDR_WIDTH-1:0] reg_rd_addr_b,
  input  logic                  reg_rd_addrs_b_valid,
  output logic [DATA_WIDTH-1:0] reg_rd_data_b,
  output logic                  reg_rd_data_b_ack,

  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  reg_wr_valid,
  output logic                  reg_wr_ack
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE
  } rd_state_t;

  logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];
  logic                  wr_ack_q;

  // Port A state
  rd_state_t             state_a, state_a_d;
  logic [CNT_W-1:0]      cnt_a, cnt_a_d;
  logic [ADDR_WIDTH-1:0] addr_q_a, addr_q_a_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [ADDR_WIDTH-1:0] cap_addr_a;
  logic [DATA_WIDTH-1:0] cap_val_a;

  // Port B state
  rd_state_t             state_b, state_b_d;
  logic [CNT_W-1:0]      cnt_b, cnt_b_d;
  logic [ADDR_WIDTH-1:0] addr_q_b, addr_q_b_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic [ADDR_WIDTH-1:0] cap_addr_b;
  logic [DATA_WIDTH-1:0] cap_val_b;

  // Register array update; x0 is never written so it keeps its reset zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_wr_valid && (reg_wr_addr != '0)) begin
      regs[reg_wr_addr] <= reg_wr_data;
    end
  end

  // Every write strobe, including x0 writes, is acknowledged one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= reg_wr_valid;
    end
  end

  assign reg_wr_ack = wr_ack_q;

  // Port A capture value: live address when capturing straight from IDLE,
  // latched address otherwise, with same-edge write-back forwarded in
  always_comb begin
    cap_addr_a = (state_a == ST_IDLE) ? reg_rd_addr_a : addr_q_a;
    cap_val_a  = '0;
    if (cap_addr_a == '0) begin
      cap_val_a = '0;
    end else if (reg_wr_valid && (reg_wr_addr == cap_addr_a)) begin
      cap_val_a = reg_wr_data;
    end else begin
      cap_val_a = regs[cap_addr_a];
    end
  end

  // Port A next-state logic for the four-phase responder
  always_comb begin
    state_a_d  = state_a;
    cnt_a_d    = cnt_a;
    addr_q_a_d = addr_q_a;
    data_a_d   = data_a_q;
    case (state_a)
      ST_IDLE: begin
        if (reg_rd_addrs_a_valid) begin
          addr_q_a_d = reg_rd_addr_a;
          if (RD_LATENCY == 1) begin
            state_a_d = ST_ACK;
            data_a_d  = cap_val_a;
          end else begin
            cnt_a_d   = CNT_W'(RD_LATENCY - 1);
            state_a_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_a == CNT_W'(1)) begin
          cnt_a_d   = '0;
          state_a_d = ST_ACK;
          data_a_d  = cap_val_a;
        end else begin
          cnt_a_d = cnt_a - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_a_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!reg_rd_addrs_a_valid) begin
          state_a_d = ST_IDLE;
        end
      end
      default: begin
        state_a_d = ST_IDLE;
      end
    endcase
  end

  // Port A state register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_a  <= ST_IDLE;
      cnt_a    <= '0;
      addr_q_a <= '0;
      data_a_q <= '0;
    end else begin
      state_a  <= state_a_d;
      cnt_a    <= cnt_a_d;
      addr_q_a <= addr_q_a_d;
      data_a_q <= data_a_d;
    end
  end

  assign reg_rd_data_a_ack = (state_a == ST_ACK);
  assign reg_rd_data_a     = data_a_q;

  // Port B capture value, same rules as port A
  always_comb begin
    cap_addr_b = (state_b == ST_IDLE) ? reg_rd_addr_b : addr_q_b;
    cap_val_b  = '0;
    if (cap_addr_b == '0) begin
      cap_val_b = '0;
    end else if (reg_wr_valid && (reg_wr_addr == cap_addr_b)) begin
      cap_val_b = reg_wr_data;
    end else begin
      cap_val_b = regs[cap_addr_b];
    end
  end

  // Port B next-state logic for the four-phase responder
  always_comb begin
    state_b_d  = state_b;
    cnt_b_d    = cnt_b;
    addr_q_b_d = addr_q_b;
    data_b_d   = data_b_q;
    case (state_b)
      ST_IDLE: begin
        if (reg_rd_addrs_b_valid) begin
          addr_q_b_d = reg_rd_addr_b;
          if (RD_LATENCY == 1) begin
            state_b_d = ST_ACK;
            data_b_d  = cap_val_b;
          end else begin
            cnt_b_d   = CNT_W'(RD_LATENCY - 1);
            state_b_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_b == CNT_W'(1)) begin
          cnt_b_d   = '0;
          state_b_d = ST_ACK;
          data_b_d  = cap_val_b;
        end else begin
          cnt_b_d = cnt_b - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_b_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!reg_rd_addrs_b_valid) begin
          state_b_d = ST_IDLE;
        end
      end
      default: begin
        state_b_d = ST_IDLE;
      end
    endcase
  end

  // Port B state register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_b  <= ST_IDLE;
      cnt_b    <= '0;
      addr_q_b <= '0;
      data_b_q <= '0;
    end else begin
      state_b  <= state_b_d;
      cnt_b    <= cnt_b_d;
      addr_q_b <= addr_q_b_d;
      data_b_q <= data_b_d;
    end
  end

  assign reg_rd_data_b_ack = (state_b == ST_ACK);
  assign reg_rd_data_b     = data_b_q;

endmodule

// File: tb/tb_risc_register_file_responder.sv
// tb_risc_register_file_responder
// Directed bench: one instance at RD_LATENCY=1 and one at RD_LATENCY=4,
// sharing clock, reset and the write-back bus, each with its own read ports.

module tb_risc_register_file_responder;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_valid;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic          a_ack, b_ack, wr_ack;

  logic [AW-1:0] a4_addr, b4_addr;
  logic          a4_valid, b4_valid;
  logic [DW-1:0] a4_data, b4_data;
  logic          a4_ack, b4_ack, wr_ack4;

  int n_checks = 0;
  int n_fail   = 0;

  risc_register_file_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .reg_rd_addr_a(a_addr), .reg_rd_addrs_a_valid(a_valid),
    .reg_rd_data_a(a_data), .reg_rd_data_a_ack(a_ack),
    .reg_rd_addr_b(b_addr), .reg_rd_addrs_b_valid(b_valid),
    .reg_rd_data_b(b_data), .reg_rd_data_b_ack(b_ack),
    .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_valid(wr_valid),
    .reg_wr_ack(wr_ack)
  );

  risc_register_file_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .reg_rd_addr_a(a4_addr), .reg_rd_addrs_a_valid(a4_valid),
    .reg_rd_data_a(a4_data), .reg_rd_data_a_ack(a4_ack),
    .reg_rd_addr_b(b4_addr), .reg_rd_addrs_b_valid(b4_valid),
    .reg_rd_data_b(b4_data), .reg_rd_data_b_ack(b4_ack),
    .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_valid(wr_valid),
    .reg_wr_ack(wr_ack4)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
    a_addr = '0; a_valid = 1'b0; b_addr = '0; b_valid = 1'b0;
    a4_addr = '0; a4_valid = 1'b0; b4_addr = '0; b4_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_a_ack: got %b expected 0", a_ack); end
    n_checks++; if (b_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_b_ack: got %b expected 0", b_ack); end
    n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_a_data: got %h expected 0", a_data); end
    n_checks++; if (b_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_b_data: got %h expected 0", b_data); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wr_ack: got %b expected 0", wr_ack); end
    n_checks++; if ((a4_ack | b4_ack) !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_lat4_acks: got %b%b expected 00", a4_ack, b4_ack); end
    a_addr = 5'd5; a_valid = 1'b1;
    step();
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_x5_ack: got %b expected 1", a_ack); end
    n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_x5_data: got %h expected 0", a_data); end
    a_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_write_read();
    wr_addr = 5'd1; wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
    step();
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL wr1_ack: got %b expected 1", wr_ack); end
    wr_valid = 1'b0; a_addr = 5'd1; a_valid = 1'b1;
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rd1_early_ack: got %b expected 0", a_ack); end
    step();
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL rd1_ack: got %b expected 1", a_ack); end
    n_checks++; if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd1_data: got %h expected deadbeef", a_data); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL wr1_ack_drop: got %b expected 0", wr_ack); end
    a_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rd1_no_reack[%0d]: got %b expected 0", i, a_ack); end
    end
    n_checks++; if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd1_data_hold: got %h expected deadbeef", a_data); end
    a_valid = 1'b0;
    step();
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rd1_release_ack: got %b expected 0", a_ack); end
    a_addr = 5'd1; a_valid = 1'b1;
    step();
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL rd1_second_ack: got %b expected 1", a_ack); end
    n_checks++; if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd1_second_data: got %h expected deadbeef", a_data); end
    a_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_x0();
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_valid = 1'b1;
    step();
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_wr_ack: got %b expected 1", wr_ack); end
    wr_valid = 1'b0; a_addr = 5'd0; a_valid = 1'b1;
    step();
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_rd_ack: got %b expected 1", a_ack); end
    n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL x0_rd_data: got %h expected 0", a_data); end
    a_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    wr_addr = 5'd2; wr_data = 32'h22220002; wr_valid = 1'b1;
    step();
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack0: got %b expected 1", wr_ack); end
    wr_addr = 5'd4; wr_data = 32'h44440004;
    step();
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack1: got %b expected 1", wr_ack); end
    wr_valid = 1'b0;
    a_addr = 5'd2; a_valid = 1'b1; b_addr = 5'd4; b_valid = 1'b1;
    step();
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ack_end: got %b expected 0", wr_ack); end
    n_checks++; if ({a_ack, b_ack} !== 2'b11) begin n_fail++; $display("[TB] FAIL b2b_rd_acks: got %b%b expected 11", a_ack, b_ack); end
    n_checks++; if (a_data !== 32'h22220002) begin n_fail++; $display("[TB] FAIL b2b_a_data: got %h expected 22220002", a_data); end
    n_checks++; if (b_data !== 32'h44440004) begin n_fail++; $display("[TB] FAIL b2b_b_data: got %h expected 44440004", b_data); end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_forwarding();
    wr_addr = 5'd3; wr_data = 32'h00000011; wr_valid = 1'b1;
    step();
    wr_data = 32'h00000022;
    a_addr = 5'd3; a_valid = 1'b1; b_addr = 5'd3; b_valid = 1'b1;
    step();
    n_checks++; if ({a_ack, b_ack} !== 2'b11) begin n_fail++; $display("[TB] FAIL fwd_acks: got %b%b expected 11", a_ack, b_ack); end
    n_checks++; if (a_data !== 32'h00000022) begin n_fail++; $display("[TB] FAIL fwd_a_data: got %h expected 00000022", a_data); end
    n_checks++; if (b_data !== 32'h00000022) begin n_fail++; $display("[TB] FAIL fwd_b_data: got %h expected 00000022", b_data); end
    wr_valid = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    step();
    step();
    a_addr = 5'd3; a_valid = 1'b1;
    step();
    n_checks++; if (a_data !== 32'h00000022) begin n_fail++; $display("[TB] FAIL fwd_later_data: got %h expected 00000022", a_data); end
    a_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_latency4();
    wr_addr = 5'd7; wr_data = 32'h77770007; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    b4_addr = 5'd7; b4_valid = 1'b1;
    step();
    b4_addr = 5'd9;
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lat4_e0: got %b expected 0", b4_ack); end
    step();
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lat4_e1: got %b expected 0", b4_ack); end
    step();
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lat4_e2: got %b expected 0", b4_ack); end
    step();
    n_checks++; if (b4_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL lat4_e3: got %b expected 1", b4_ack); end
    n_checks++; if (b4_data !== 32'h77770007) begin n_fail++; $display("[TB] FAIL lat4_data: got %h expected 77770007", b4_data); end
    step();
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lat4_single: got %b expected 0", b4_ack); end
    b4_valid = 1'b0;
    step();
    // Request again, dropping valid while the FSM is still waiting
    b4_addr = 5'd7; b4_valid = 1'b1;
    step();
    b4_valid = 1'b0;
    step();
    step();
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_e2: got %b expected 0", b4_ack); end
    step();
    n_checks++; if (b4_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_ack: got %b expected 1", b4_ack); end
    step();
    n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_release: got %b expected 0", b4_ack); end
    step();
    b4_addr = 5'd2; b4_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (b4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_next_wait[%0d]: got %b expected 0", i, b4_ack); end
    end
    step();
    n_checks++; if (b4_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_next_ack: got %b expected 1", b4_ack); end
    n_checks++; if (b4_data !== 32'h22220002) begin n_fail++; $display("[TB] FAIL drop_next_data: got %h expected 22220002", b4_data); end
    b4_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    a4_addr = 5'd7; a4_valid = 1'b1;
    step();
    step();
    reset = 1'b0;
    a4_valid = 1'b0;
    #1;
    n_checks++; if (a4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_ack: got %b expected 0", a4_ack); end
    n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_rst_a_data: got %h expected 0", a_data); end
    n_checks++; if (b_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_rst_b_data: got %h expected 0", b_data); end
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (a4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_ack[%0d]: got %b expected 0", i, a4_ack); end
    end
    a4_addr = 5'd7; a4_valid = 1'b1;
    a_addr = 5'd1; a_valid = 1'b1;
    step();
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_x1_ack: got %b expected 1", a_ack); end
    n_checks++; if (a_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_x1_data: got %h expected 0", a_data); end
    a_valid = 1'b0;
    step();
    step();
    n_checks++; if (a4_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_new_e2: got %b expected 0", a4_ack); end
    step();
    n_checks++; if (a4_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_new_ack: got %b expected 1", a4_ack); end
    n_checks++; if (a4_data !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_new_data: got %h expected 0", a4_data); end
    a4_valid = 1'b0;
    step();
    step();
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_back_to_back();
    test_forwarding();
    test_latency4();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
